// File: rtl/cpu6502_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu6502_sequencer_if
// Purpose  : Microcode/flag/interrupt bundle between the 6502 datapath and
//            its sequencer.
// Revision : 1.0
// ============================================================================
interface cpu6502_sequencer_if #(
    parameter int STATE_WIDTH  = 9,
    parameter int OPCODE_WIDTH = 8
);
    logic                    enable;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [STATE_WIDTH-1:0]  nextOptionA;
    logic [STATE_WIDTH-1:0]  nextOptionB;
    logic [2:0]              nextSelect;
    logic                    instructionEnd;
    logic                    negativeFlag;
    logic                    zeroFlag;
    logic                    overflowFlag;
    logic                    carryFlag;
    logic                    fixPage;
    logic                    writeBack;
    logic                    interruptDisable;
    logic                    interrupt_N;
    logic                    nonMaskableInterrupt_N;
    logic [STATE_WIDTH-1:0]  currentState;
    logic [1:0]              vectorSelect;
    logic                    interruptTaken;

    modport master (
        output enable, opcode, nextOptionA, nextOptionB, nextSelect,
               instructionEnd, negativeFlag, zeroFlag, overflowFlag,
               carryFlag, fixPage, writeBack, interruptDisable,
               interrupt_N, nonMaskableInterrupt_N,
        input  currentState, vectorSelect, interruptTaken
    );

    modport slave (
        input  enable, opcode, nextOptionA, nextOptionB, nextSelect,
               instructionEnd, negativeFlag, zeroFlag, overflowFlag,
               carryFlag, fixPage, writeBack, interruptDisable,
               interrupt_N, nonMaskableInterrupt_N,
        output currentState, vectorSelect, interruptTaken
    );
endinterface
`default_nettype wire

// File: rtl/cpu6502_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu6502_sequencer
// Purpose  : 6502 microcode state sequencer with NMI/IRQ entry and vector select.
// Revision : 1.0
// ============================================================================
module cpu6502_sequencer #(
    parameter int                     STATE_WIDTH  = 9,
    parameter int                     OPCODE_WIDTH = 8,
    parameter logic [STATE_WIDTH-1:0] RESET_STATE  = 9'h001,
    parameter logic [STATE_WIDTH-1:0] NMI_STATE    = 9'h002,
    parameter logic [STATE_WIDTH-1:0] IRQ_STATE    = 9'h003
) (
    input  wire logic          clock,
    input  wire logic          reset_N,
    cpu6502_sequencer_if.slave bus
);

    localparam logic [1:0] VEC_RESET = 2'b11;
    localparam logic [1:0] VEC_NMI   = 2'b01;
    localparam logic [1:0] VEC_IRQ   = 2'b10;

    logic [STATE_WIDTH-1:0] current_state;
    logic [1:0]             vector_select;
    logic                   interrupt_taken;
    logic                   nmi_prev;
    logic                   nmi_pending;

    logic [STATE_WIDTH-1:0] dispatch_state;
    logic [STATE_WIDTH-1:0] computed_next;
    logic                   branch_cond;
    logic                   nmi_fall;
    logic                   irq_active;
    logic                   boundary;
    logic                   take_nmi;
    logic                   take_irq;

    always_comb begin
        dispatch_state                   = '0;
        dispatch_state[OPCODE_WIDTH-1:0] = bus.opcode;
        dispatch_state[STATE_WIDTH-1]    = 1'b1;

        case (bus.nextSelect)
            3'd2:    branch_cond = bus.carryFlag;
            3'd3:    branch_cond = bus.overflowFlag;
            3'd4:    branch_cond = bus.negativeFlag;
            3'd5:    branch_cond = bus.zeroFlag;
            3'd6:    branch_cond = bus.writeBack;
            3'd7:    branch_cond = bus.fixPage;
            default: branch_cond = 1'b1;
        endcase

        if (bus.nextSelect == 3'd1) begin
            computed_next = dispatch_state;
        end else begin
            computed_next = branch_cond ? bus.nextOptionA : bus.nextOptionB;
        end
    end

    // Decisions use the registered pending flag, so an edge arriving on a
    // boundary cycle is only acted on at the following boundary.
    assign nmi_fall   = nmi_prev && !bus.nonMaskableInterrupt_N;
    assign irq_active = !bus.interrupt_N && !bus.interruptDisable;
    assign boundary   = bus.enable && bus.instructionEnd;
    assign take_nmi   = boundary && nmi_pending;
    assign take_irq   = boundary && !nmi_pending && irq_active;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            current_state   <= RESET_STATE;
            vector_select   <= VEC_RESET;
            interrupt_taken <= 1'b0;
            nmi_prev        <= 1'b1;
            nmi_pending     <= 1'b0;
        end else begin
            nmi_prev        <= bus.nonMaskableInterrupt_N;
            nmi_pending     <= nmi_fall || (nmi_pending && !take_nmi);
            interrupt_taken <= take_nmi || take_irq;
            if (take_nmi) begin
                current_state <= NMI_STATE;
                vector_select <= VEC_NMI;
            end else if (take_irq) begin
                current_state <= IRQ_STATE;
                vector_select <= VEC_IRQ;
            end else if (bus.enable) begin
                current_state <= computed_next;
            end
        end
    end

    assign bus.currentState   = current_state;
    assign bus.vectorSelect   = vector_select;
    assign bus.interruptTaken = interrupt_taken;

endmodule
`default_nettype wire

// File: tb/tb_cpu6502_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu6502_sequencer
// Purpose  : Directed vector table plus randomized run against a reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cpu6502_sequencer;

    logic clock = 1'b0;
    logic reset_N;
    always #5 clock = ~clock;

    cpu6502_sequencer_if #(.STATE_WIDTH(9), .OPCODE_WIDTH(8)) bus ();

    cpu6502_sequencer #(
        .STATE_WIDTH (9),
        .OPCODE_WIDTH(8),
        .RESET_STATE (9'h001),
        .NMI_STATE   (9'h002),
        .IRQ_STATE   (9'h003)
    ) dut (
        .clock  (clock),
        .reset_N(reset_N),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // flags = {negative, zero, overflow, carry, fixPage, writeBack}
    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [8:0] a;
        logic [8:0] b;
        logic [7:0] op;
        logic [5:0] flags;
        logic       ie;
        logic       irq_n;
        logic       idis;
        logic       nmi_n;
        logic [8:0] es;
        logic [1:0] ev;
        logic       et;
    } vec_t;

    vec_t tbl[$];

    logic [8:0] m_state;
    logic [1:0] m_vec;
    logic       m_taken;
    logic       m_pending;
    logic       m_prev;

    task automatic add(input logic en, input logic [2:0] sel, input logic [8:0] a,
                       input logic [8:0] b, input logic [7:0] op, input logic [5:0] flags,
                       input logic ie, input logic irq_n, input logic idis, input logic nmi_n,
                       input logic [8:0] es, input logic [1:0] ev, input logic et);
        vec_t v;
        v.en = en; v.sel = sel; v.a = a; v.b = b; v.op = op; v.flags = flags;
        v.ie = ie; v.irq_n = irq_n; v.idis = idis; v.nmi_n = nmi_n;
        v.es = es; v.ev = ev; v.et = et;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        bus.enable                 = v.en;
        bus.nextSelect             = v.sel;
        bus.nextOptionA            = v.a;
        bus.nextOptionB            = v.b;
        bus.opcode                 = v.op;
        bus.negativeFlag           = v.flags[5];
        bus.zeroFlag               = v.flags[4];
        bus.overflowFlag           = v.flags[3];
        bus.carryFlag              = v.flags[2];
        bus.fixPage                = v.flags[1];
        bus.writeBack              = v.flags[0];
        bus.instructionEnd         = v.ie;
        bus.interrupt_N            = v.irq_n;
        bus.interruptDisable       = v.idis;
        bus.nonMaskableInterrupt_N = v.nmi_n;
    endtask

    task automatic check(input string name, input logic [8:0] es, input logic [1:0] ev,
                         input logic et);
        checks++;
        if (bus.currentState !== es || bus.vectorSelect !== ev || bus.interruptTaken !== et) begin
            failures++;
            $display("FAIL %s: got state=%h vec=%b taken=%b, required state=%h vec=%b taken=%b",
                     name, bus.currentState, bus.vectorSelect, bus.interruptTaken, es, ev, et);
        end
    endtask

    // Reference: priority NMI > IRQ > microcode, taken only on enabled boundaries.
    task automatic model_step();
        logic [7:0] cond;
        logic       nmi_now;
        logic       edge_seen;
        cond = {bus.fixPage, bus.writeBack, bus.zeroFlag, bus.negativeFlag,
                bus.overflowFlag, bus.carryFlag, 1'b1, 1'b1};
        nmi_now = 1'b0;
        if (!bus.enable) begin
            m_taken = 1'b0;
        end else if (bus.instructionEnd && m_pending) begin
            m_state = 9'h002; m_vec = 2'b01; m_taken = 1'b1; nmi_now = 1'b1;
        end else if (bus.instructionEnd && !bus.interrupt_N && !bus.interruptDisable) begin
            m_state = 9'h003; m_vec = 2'b10; m_taken = 1'b1;
        end else begin
            m_taken = 1'b0;
            if (bus.nextSelect == 3'd1) m_state = 9'h100 + {1'b0, bus.opcode};
            else m_state = cond[bus.nextSelect] ? bus.nextOptionA : bus.nextOptionB;
        end
        edge_seen = m_prev && !bus.nonMaskableInterrupt_N;
        if (nmi_now) m_pending = 1'b0;
        if (edge_seen) m_pending = 1'b1;
        m_prev = bus.nonMaskableInterrupt_N;
    endtask

    initial begin
        vec_t v;
        //   en sel  A       B       op     flags      ie irq idis nmi  state   vec   taken
        add(1, 0, 9'h010, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h010, 2'b11, 0);
        add(1, 1, 9'h000, 9'h000, 8'hA9, 6'b000000, 0, 1, 1, 1, 9'h1A9, 2'b11, 0);
        add(1, 2, 9'h020, 9'h030, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h030, 2'b11, 0);
        add(1, 2, 9'h020, 9'h030, 8'h00, 6'b000100, 0, 1, 1, 1, 9'h020, 2'b11, 0);
        add(1, 3, 9'h040, 9'h050, 8'h00, 6'b001000, 0, 1, 1, 1, 9'h040, 2'b11, 0);
        add(1, 4, 9'h040, 9'h050, 8'h00, 6'b011111, 0, 1, 1, 1, 9'h050, 2'b11, 0);
        add(1, 5, 9'h040, 9'h050, 8'h00, 6'b010000, 0, 1, 1, 1, 9'h040, 2'b11, 0);
        add(1, 6, 9'h040, 9'h050, 8'h00, 6'b111110, 0, 1, 1, 1, 9'h050, 2'b11, 0);
        add(1, 7, 9'h040, 9'h050, 8'h00, 6'b000010, 0, 1, 1, 1, 9'h040, 2'b11, 0);
        // NMI falls mid-instruction and is then held low across boundaries
        add(1, 0, 9'h060, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 0, 9'h060, 2'b11, 0);
        add(1, 0, 9'h061, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 0, 9'h061, 2'b11, 0);
        add(1, 0, 9'h070, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h002, 2'b01, 1);
        add(1, 0, 9'h073, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h073, 2'b01, 0);
        add(1, 0, 9'h074, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h074, 2'b01, 0);
        add(1, 0, 9'h075, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h075, 2'b01, 0);
        // IRQ masked, then unmasked
        add(1, 0, 9'h080, 9'h000, 8'h00, 6'b000000, 1, 0, 1, 1, 9'h080, 2'b01, 0);
        add(1, 0, 9'h081, 9'h000, 8'h00, 6'b000000, 0, 0, 0, 1, 9'h081, 2'b01, 0);
        add(1, 0, 9'h082, 9'h000, 8'h00, 6'b000000, 1, 0, 0, 1, 9'h003, 2'b10, 1);
        add(1, 0, 9'h083, 9'h000, 8'h00, 6'b000000, 1, 1, 0, 1, 9'h083, 2'b10, 0);
        // NMI and IRQ at the same boundary
        add(1, 0, 9'h090, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 0, 9'h090, 2'b10, 0);
        add(1, 0, 9'h091, 9'h000, 8'h00, 6'b000000, 1, 0, 0, 1, 9'h002, 2'b01, 1);
        add(1, 0, 9'h092, 9'h000, 8'h00, 6'b000000, 1, 0, 0, 1, 9'h003, 2'b10, 1);
        add(1, 0, 9'h0A0, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h0A0, 2'b10, 0);
        // five-cycle stall with an NMI edge inside
        add(0, 0, 9'h0B0, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h0A0, 2'b10, 0);
        add(0, 0, 9'h0B0, 9'h000, 8'h00, 6'b000000, 1, 0, 0, 0, 9'h0A0, 2'b10, 0);
        add(0, 0, 9'h0B0, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h0A0, 2'b10, 0);
        add(0, 0, 9'h0B0, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h0A0, 2'b10, 0);
        add(0, 0, 9'h0B0, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 1, 9'h0A0, 2'b10, 0);
        add(1, 0, 9'h0B1, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 1, 9'h002, 2'b01, 1);
        add(1, 0, 9'h0B2, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h0B2, 2'b01, 0);
        // edge on the boundary cycle is deferred to the next boundary
        add(1, 0, 9'h0C0, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h0C0, 2'b01, 0);
        add(1, 0, 9'h0C1, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 1, 9'h002, 2'b01, 1);
        // new edge while pending is consumed: pending survives
        add(1, 0, 9'h0D0, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 0, 9'h0D0, 2'b01, 0);
        add(1, 0, 9'h0D1, 9'h000, 8'h00, 6'b000000, 0, 1, 1, 1, 9'h0D1, 2'b01, 0);
        add(1, 0, 9'h0D2, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h002, 2'b01, 1);
        add(1, 0, 9'h0D3, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 0, 9'h002, 2'b01, 1);
        add(1, 0, 9'h0D4, 9'h000, 8'h00, 6'b000000, 1, 1, 1, 1, 9'h0D4, 2'b01, 0);

        reset_N = 1'b0;
        apply(tbl[0]);
        #12;
        check("reset_hold", 9'h001, 2'b11, 1'b0);
        repeat (2) @(posedge clock);
        #3;
        check("reset_clocked", 9'h001, 2'b11, 1'b0);
        @(negedge clock);
        reset_N = 1'b1;
        #1;
        check("reset_release", 9'h001, 2'b11, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), tbl[i].es, tbl[i].ev, tbl[i].et);
        end

        // reset mid-instruction discards a pending NMI
        v = tbl[0];
        v.a = 9'h0E1; v.nmi_n = 1'b0;
        apply(v);
        @(posedge clock);
        #1;
        check("pre_reset_nmi", 9'h0E1, 2'b01, 1'b0);
        #2;
        reset_N = 1'b0;
        #1;
        check("reset_async", 9'h001, 2'b11, 1'b0);
        bus.nonMaskableInterrupt_N = 1'b1;
        @(negedge clock);
        reset_N = 1'b1;
        bus.nextOptionA    = 9'h0E0;
        bus.instructionEnd = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset_no_nmi", 9'h0E0, 2'b11, 1'b0);

        m_state = 9'h0E0; m_vec = 2'b11; m_taken = 1'b0; m_pending = 1'b0; m_prev = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus.enable           = ($urandom_range(0, 9) < 8);
            bus.nextSelect       = 3'($urandom_range(0, 7));
            bus.nextOptionA      = 9'($urandom);
            bus.nextOptionB      = 9'($urandom);
            bus.opcode           = 8'($urandom);
            bus.negativeFlag     = 1'($urandom);
            bus.zeroFlag         = 1'($urandom);
            bus.overflowFlag     = 1'($urandom);
            bus.carryFlag        = 1'($urandom);
            bus.fixPage          = 1'($urandom);
            bus.writeBack        = 1'($urandom);
            bus.instructionEnd   = ($urandom_range(0, 9) < 3);
            bus.interrupt_N      = ($urandom_range(0, 9) >= 3);
            bus.interruptDisable = 1'($urandom);
            if ($urandom_range(0, 4) == 0)
                bus.nonMaskableInterrupt_N = ~bus.nonMaskableInterrupt_N;
            model_step();
            @(posedge clock);
            #1;
            check($sformatf("rand%0d", i), m_state, m_vec, m_taken);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu6502_sequencer.md
# cpu6502_sequencer

Parametrised microcode sequencer for the 6502 core. It owns the current-state register and computes each next state from the microcode's next-state fields, the opcode, and the ALU/address flags. It also adds hardware interrupt entry: NMI falling-edge latching, maskable IRQ sampling at instruction boundaries, and vector selection. The microcode ROM sits outside the block; it is indexed by `currentState` and returns the next-state fields combinationally.

## Interface
- `STATE_WIDTH`, default 9: width of the state register; must be ≥ `OPCODE_WIDTH`+1.
- `OPCODE_WIDTH`, default 8: opcode width.
- `RESET_STATE`, default 9'h001: state entered on reset.
- `NMI_STATE`, default 9'h002: NMI entry state.
- `IRQ_STATE`, default 9'h003: IRQ entry state.
- `clock`  in  1  single clock, rising edge.
- `reset_N`  in  1  asynchronous, active-low reset.
- `enable`  in  1  advance the sequencer this cycle; low = stall.
- `opcode`  in  OPCODE_WIDTH  fetched opcode, used for dispatch.
- `nextOptionA`  in  STATE_WIDTH  microcode target A.
- `nextOptionB`  in  STATE_WIDTH  microcode target B.
- `nextSelect`  in  3  next-state determination code (see Operation).
- `instructionEnd`  in  1  microcode marks the current state as the last of its instruction.
- `negativeFlag`, `zeroFlag`, `overflowFlag`, `carryFlag`, `fixPage`, `writeBack`  in  1 each  branch conditions.
- `interruptDisable`  in  1  I flag; high masks IRQ.
- `interrupt_N`  in  1  IRQ, active-low, level.
- `nonMaskableInterrupt_N`  in  1  NMI, active-low, falling-edge.
- `currentState`  out  STATE_WIDTH  registered current state.
- `vectorSelect`  out  2  registered vector selector: 2'b11 reset (FFFC), 2'b01 NMI (FFFA), 2'b10 IRQ (FFFE).
- `interruptTaken`  out  1  one-cycle pulse on NMI or IRQ entry.

## Operation
- **Computed next state** (`nextSelect`):
  - 0: A.
  - 1: dispatch, `{1'b1, zero-pad, opcode}`.
  - 2: carry ? A : B.
  - 3: overflow ? A : B.
  - 4: negative ? A : B.
  - 5: zero ? A : B.
  - 6: writeBack ? A : B.
  - 7: fixPage ? A : B.
- **NMI detection:**
  - `nmiPrev` samples `nonMaskableInterrupt_N` every cycle, regardless of `enable`.
  - `nmiPrev`=1 with the current input at 0 sets `nmiPending`.
- **IRQ condition:** `irqActive` = `!interrupt_N && !interruptDisable`, evaluated combinationally. It is not latched.
- **Update when `enable`=1:**
  - If `instructionEnd`=1 and `nmiPending`: currentState←`NMI_STATE`, vectorSelect←2'b01, nmiPending cleared, interruptTaken←1.
  - Else if `instructionEnd`=1 and `irqActive`: currentState←`IRQ_STATE`, vectorSelect←2'b10, interruptTaken←1.
  - Otherwise: currentState←computed next state, interruptTaken←0.
- **Update when `enable`=0:** currentState and vectorSelect hold; interruptTaken←0. NMI edge detection continues.
- **Priority:** NMI > IRQ > microcode. The `instructionEnd` gating means an interrupt is never taken mid-instruction.

## Timing
- **Reset values** (immediate on `reset_N` low, independent of clock): currentState=`RESET_STATE`, vectorSelect=2'b11, interruptTaken=0, nmiPending=0, nmiPrev=1.
- **Latency:** all outputs are registered. The next state appears one clock after the enabled cycle whose inputs determine it.
- **NMI edge and boundary in the same cycle:** the edge is not visible to that boundary decision. NMI is taken at the next enabled `instructionEnd`.
- **New NMI edge in the cycle pending is consumed:** set wins; nmiPending stays 1.
- **NMI held low:** yields exactly one entry. Re-arming requires a return high, then a new fall.
- **IRQ deassertion:** IRQ deasserted or masked before `instructionEnd` is lost, by design.
- **Stalls:** an NMI edge during a stall is retained. `interruptTaken` never pulses on a stalled cycle.
- **Reset mid-instruction:** pending NMI is discarded; sequencing restarts at `RESET_STATE` on the first enabled cycle after release.

## Test plan
- **Reset:** release reset, `enable`=1, `nextSelect`=0, A=9'h010 -> currentState 9'h001, then 9'h010; vectorSelect=2'b11; interruptTaken=0.
- **Dispatch and branch:**
  - `nextSelect`=1, opcode=8'hA9 -> currentState=9'h1A9.
  - `nextSelect`=2, A=9'h020, B=9'h030, carry=0 -> 9'h030.
- **NMI edge:** pulse NMI low for one cycle mid-instruction, then `instructionEnd`=1 -> currentState=9'h002, vectorSelect=2'b01, interruptTaken=1 for exactly one cycle. Holding NMI low across further boundaries gives no second entry.
- **IRQ masking:**
  - `interrupt_N`=0, `interruptDisable`=1 at boundary -> normal next state.
  - Clear I -> at next boundary currentState=9'h003, vectorSelect=2'b10.
- **Simultaneous NMI and IRQ:** NMI pending and IRQ asserted at the same boundary -> NMI_STATE first. IRQ still asserted at the next boundary -> IRQ_STATE.
- **Stall:** `enable`=0 for 5 cycles with an NMI falling edge inside -> currentState frozen, no pulse. After `enable`=1 with `instructionEnd`=1 -> NMI_STATE.
